terminal_writer: RTL

//  Parametrised successor to the character writer: consumes the PS/2 character stream and

---
 rtl/terminal_writer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/terminal_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : terminal_writer
//  Description : Text-terminal front end for the VRAM write port. Consumes
//                ASCII bytes, tracks a cursor, handles CR/LF/BS/TAB, wraps at
//                the right margin, scrolls by advancing top_row and blanks
//                recycled lines. Can optionally blank the screen after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module terminal_writer #(
    parameter int          ROWS           = 30,
    parameter int          COLS           = 80,
    parameter int          TAB_WIDTH      = 8,
    parameter logic [7:0]  BLANK          = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int         ROW_W          = $clog2(ROWS),
    localparam int         COL_W          = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset_low,
    output logic             character_ready,
    input  logic             character_valid,
    input  logic [7:0]       character_byte,
    input  logic             write_ready,
    output logic             write_valid,
    output logic [ROW_W-1:0] write_row,
    output logic [COL_W-1:0] write_col,
    output logic [7:0]       write_byte,
    output logic [ROW_W-1:0] top_row,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE      = 2'd1,
        S_CLEAR_LINE = 2'd2,
        S_CLEAR_ALL  = 2'd3
    } state_t;

    localparam state_t           c_reset_state = CLEAR_ON_RESET ? S_CLEAR_ALL : S_IDLE;
    localparam logic [ROW_W-1:0] c_last_row    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_last_col    = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_row_one     = ROW_W'(1);
    localparam logic [COL_W-1:0] c_col_one     = COL_W'(1);
    localparam logic [COL_W:0]   c_tab_mask    = (COL_W+1)'(TAB_WIDTH - 1);
    localparam logic [COL_W:0]   c_tab_one     = (COL_W+1)'(1);
    localparam logic [COL_W:0]   c_cols_ext    = (COL_W+1)'(COLS);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ready;
    logic             r_write_valid;
    logic [ROW_W-1:0] r_write_row;
    logic [COL_W-1:0] r_write_col;
    logic [7:0]       r_write_byte;
    logic             r_pend_bs;
    logic [ROW_W-1:0] r_top_row;
    logic [ROW_W-1:0] r_cur_row;
    logic [COL_W-1:0] r_cur_col;

    logic             w_accept;
    logic             w_hs;
    logic             w_printable;
    logic [ROW_W-1:0] w_nl_row;
    logic [ROW_W-1:0] w_top_inc;
    logic             w_nl_scroll;
    logic [COL_W:0]   w_tab_sum;
    logic             w_tab_ovf;
    logic             w_do_write;
    logic             w_is_bs;
    logic [COL_W-1:0] w_wr_col;
    logic [7:0]       w_wr_byte;
    logic             w_take_nl;

    // Handshakes and newline/tab arithmetic shared by all processes
    assign w_accept    = r_ready & character_valid;
    assign w_hs        = r_write_valid & write_ready;
    assign w_printable = (character_byte >= 8'h20) && (character_byte <= 8'h7E);
    assign w_nl_row    = (r_cur_row == c_last_row) ? '0 : r_cur_row + c_row_one;
    assign w_top_inc   = (r_top_row == c_last_row) ? '0 : r_top_row + c_row_one;
    assign w_nl_scroll = (w_nl_row == r_top_row);
    assign w_tab_sum   = ({1'b0, r_cur_col} | c_tab_mask) + c_tab_one;
    assign w_tab_ovf   = (w_tab_sum >= c_cols_ext);

    // Byte decode and next-state selection
    always_comb begin
        w_next_state = r_state;
        w_do_write   = 1'b0;
        w_is_bs      = 1'b0;
        w_wr_col     = r_cur_col;
        w_wr_byte    = character_byte;
        w_take_nl    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_do_write   = 1'b1;
                        w_next_state = S_WRITE;
                    end else begin
                        case (character_byte)
                            8'h0A: w_take_nl = 1'b1;
                            8'h09: w_take_nl = w_tab_ovf;
                            8'h08: begin
                                if (r_cur_col != '0) begin
                                    w_do_write   = 1'b1;
                                    w_is_bs      = 1'b1;
                                    w_wr_col     = r_cur_col - c_col_one;
                                    w_wr_byte    = BLANK;
                                    w_next_state = S_WRITE;
                                end
                            end
                            default: ;
                        endcase
                        if (w_take_nl && w_nl_scroll) begin
                            w_next_state = S_CLEAR_LINE;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (w_hs) begin
                    // A printable in the last column wraps after its cell write
                    w_take_nl    = !r_pend_bs && (r_cur_col == c_last_col);
                    w_next_state = (w_take_nl && w_nl_scroll) ? S_CLEAR_LINE : S_IDLE;
                end
            end
            S_CLEAR_LINE: begin
                if (w_hs && (r_write_col == c_last_col)) begin
                    w_next_state = S_IDLE;
                end
            end
            S_CLEAR_ALL: begin
                if (w_hs && (r_write_row == c_last_row) && (r_write_col == c_last_col)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready is registered so it only rises after a full idle cycle
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == S_IDLE) && !w_accept;
        end
    end

    // Cursor and scroll position
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_top_row <= '0;
        end else if (w_take_nl) begin
            r_cur_col <= '0;
            r_cur_row <= w_nl_row;
            if (w_nl_scroll) begin
                r_top_row <= w_top_inc;
            end
        end else if ((r_state == S_IDLE) && w_accept) begin
            if (character_byte == 8'h0D) begin
                r_cur_col <= '0;
            end else if (character_byte == 8'h09) begin
                r_cur_col <= w_tab_sum[COL_W-1:0];
            end
        end else if ((r_state == S_WRITE) && w_hs) begin
            r_cur_col <= r_pend_bs ? r_cur_col - c_col_one : r_cur_col + c_col_one;
        end
    end

    // VRAM write port: single cell writes and line/screen blanking sweeps
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_write_valid <= 1'b0;
            r_write_row   <= '0;
            r_write_col   <= '0;
            r_write_byte  <= '0;
            r_pend_bs     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_do_write) begin
                        r_write_valid <= 1'b1;
                        r_write_row   <= r_cur_row;
                        r_write_col   <= w_wr_col;
                        r_write_byte  <= w_wr_byte;
                        r_pend_bs     <= w_is_bs;
                    end else if (w_next_state == S_CLEAR_LINE) begin
                        // The recycled line is the one the cursor moves onto
                        r_write_valid <= 1'b1;
                        r_write_row   <= w_nl_row;
                        r_write_col   <= '0;
                        r_write_byte  <= BLANK;
                    end else if (w_hs) begin
                        r_write_valid <= 1'b0;
                    end
                end
                S_CLEAR_LINE: begin
                    if (w_hs) begin
                        if (r_write_col == c_last_col) begin
                            r_write_valid <= 1'b0;
                        end else begin
                            r_write_col <= r_write_col + c_col_one;
                        end
                    end
                end
                default: begin
                    // Full-screen blank; the cell counter starts at (0,0) from reset
                    if (!r_write_valid) begin
                        r_write_valid <= 1'b1;
                        r_write_byte  <= BLANK;
                    end else if (w_hs) begin
                        if (r_write_col == c_last_col) begin
                            r_write_col <= '0;
                            if (r_write_row == c_last_row) begin
                                r_write_valid <= 1'b0;
                            end else begin
                                r_write_row <= r_write_row + c_row_one;
                            end
                        end else begin
                            r_write_col <= r_write_col + c_col_one;
                        end
                    end
                end
            endcase
        end
    end

    assign character_ready = r_ready;
    assign write_valid     = r_write_valid;
    assign write_row       = r_write_row;
    assign write_col       = r_write_col;
    assign write_byte      = r_write_byte;
    assign top_row         = r_top_row;
    assign cursor_row      = r_cur_row;
    assign cursor_col      = r_cur_col;

endmodule
`default_nettype wire
